// File: rtl/endstop_pkg.sv
`default_nettype none
// ============================================================================
// Package   : endstop_pkg
// Purpose   : Shared encodings for the endstop homing controller: FSM state
//             type, run completion status codes and axis select codes.
// Revision  : 1.0 - initial release
// ============================================================================
package endstop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_HIT     = 2'd0;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_BADAXIS = 2'd2;
  localparam logic [1:0] STATUS_CANCEL  = 2'd3;

  localparam logic [1:0] AXIS_NONE = 2'd0;
  localparam logic [1:0] AXIS_X    = 2'd1;
  localparam logic [1:0] AXIS_Y    = 2'd2;
  localparam logic [1:0] AXIS_Z    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/endstop_homing_ctrl_cycle_down_counter.sv
`default_nettype none
// ============================================================================
// Module    : cycle_down_counter
// Purpose   : Loadable down counter that saturates at zero.
// Ports     : clk_i      - system clock
//             rst_ni     - asynchronous active-low reset
//             load_i     - load load_val_i (wins over en_i)
//             en_i       - decrement by one while non-zero
//             load_val_i - value to load
//             zero_o     - count is zero
// Revision  : 1.0 - initial release
// ============================================================================
module cycle_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/endstop_homing_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : endstop_homing_ctrl
// Purpose   : Sequences one homing/probe run on the muxed endstop channel:
//             select axis, pulse the debouncer unlock, settle, then enable
//             motion abort until the endstop hits, the watchdog expires or
//             the host cancels. Captures hit position and bounce statistic.
// Ports     : clk_i / rst_ni          - clock, async active-low reset
//             start_i, cancel_i       - host run control
//             axis_i, polarity_i      - run target (axis 0 is illegal)
//             settle_cycles_i         - cycles between unlock and abort enable
//             watchdog_i              - max WAIT cycles, 0 = no timeout
//             es_signal_i, es_pos_i,
//             es_max_bounce_i         - from endstop debouncer
//             es_mux_select_o, es_abort_pol_o, es_abort_en_o,
//             es_unlock_o             - to endstop mux/debouncer
//             busy_o, done_o, status_o,
//             hit_pos_o, hit_bounce_o - to host register block
// Revision  : 1.0 - initial release
// ============================================================================
module endstop_homing_ctrl #(
  parameter int SETTLE_W = 16,
  parameter int WDOG_W   = 32,
  parameter int POS_W    = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                cancel_i,
  input  logic [1:0]          axis_i,
  input  logic                polarity_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [WDOG_W-1:0]   watchdog_i,
  input  logic                es_signal_i,
  input  logic [POS_W-1:0]    es_pos_i,
  input  logic [31:0]         es_max_bounce_i,
  output logic [1:0]          es_mux_select_o,
  output logic                es_abort_pol_o,
  output logic                es_abort_en_o,
  output logic                es_unlock_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [POS_W-1:0]    hit_pos_o,
  output logic [31:0]         hit_bounce_o
);

  import endstop_pkg::*;

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic [1:0]          es_mux_select_q;
  logic                es_abort_pol_q;
  logic                es_abort_en_q;
  logic                es_unlock_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          status_q;
  logic [POS_W-1:0]    hit_pos_q;
  logic [31:0]         hit_bounce_q;

  logic settle_load, settle_zero;
  logic wdog_load, wdog_zero;
  logic es_hit;

  // Counters are loaded with N-1 so that the zero flag marks the last of
  // exactly N cycles spent in SETTLE / WAIT.
  assign settle_load = (state_q == ST_ARM) && (settle_q != '0);
  assign wdog_load   = ((state_q == ST_ARM) && (settle_q == '0)) ||
                       ((state_q == ST_SETTLE) && settle_zero);

  // Level compare: a switch that is already active hits on the first WAIT cycle.
  assign es_hit = (es_signal_i == es_abort_pol_q);

  cycle_down_counter #(.WIDTH(SETTLE_W)) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (settle_load),
    .en_i       (state_q == ST_SETTLE),
    .load_val_i (settle_q - SETTLE_W'(1)),
    .zero_o     (settle_zero)
  );

  cycle_down_counter #(.WIDTH(WDOG_W)) u_wdog_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (wdog_load),
    .en_i       (state_q == ST_WAIT),
    .load_val_i (wdog_q - WDOG_W'(1)),
    .zero_o     (wdog_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      settle_q        <= '0;
      wdog_q          <= '0;
      es_mux_select_q <= '0;
      es_abort_pol_q  <= 1'b0;
      es_abort_en_q   <= 1'b0;
      es_unlock_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      status_q        <= '0;
      hit_pos_q       <= '0;
      hit_bounce_q    <= '0;
    end else begin
      es_unlock_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (axis_i != AXIS_NONE) begin
              state_q         <= ST_ARM;
              es_unlock_q     <= 1'b1;
              es_mux_select_q <= axis_i;
              es_abort_pol_q  <= polarity_i;
              settle_q        <= settle_cycles_i;
              wdog_q          <= watchdog_i;
              status_q        <= STATUS_HIT;
            end else begin
              // Illegal axis: report immediately, leave mux/pol/capture alone.
              state_q  <= ST_FINISH;
              done_q   <= 1'b1;
              status_q <= STATUS_BADAXIS;
            end
          end
        end
        ST_ARM: begin
          if (cancel_i) begin
            state_q  <= ST_FINISH;
            done_q   <= 1'b1;
            status_q <= STATUS_CANCEL;
          end else if (settle_q == '0) begin
            state_q       <= ST_WAIT;
            es_abort_en_q <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cancel_i) begin
            state_q  <= ST_FINISH;
            done_q   <= 1'b1;
            status_q <= STATUS_CANCEL;
          end else if (settle_zero) begin
            state_q       <= ST_WAIT;
            es_abort_en_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Priority: cancel, then hit, then watchdog expiry.
          if (cancel_i) begin
            state_q       <= ST_FINISH;
            es_abort_en_q <= 1'b0;
            done_q        <= 1'b1;
            status_q      <= STATUS_CANCEL;
          end else if (es_hit) begin
            state_q       <= ST_FINISH;
            es_abort_en_q <= 1'b0;
            done_q        <= 1'b1;
            status_q      <= STATUS_HIT;
            hit_pos_q     <= es_pos_i;
            hit_bounce_q  <= es_max_bounce_i;
          end else if ((wdog_q != '0) && wdog_zero) begin
            state_q       <= ST_FINISH;
            es_abort_en_q <= 1'b0;
            done_q        <= 1'b1;
            status_q      <= STATUS_TIMEOUT;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q       <= ST_IDLE;
          busy_q        <= 1'b0;
          es_abort_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign es_mux_select_o = es_mux_select_q;
  assign es_abort_pol_o  = es_abort_pol_q;
  assign es_abort_en_o   = es_abort_en_q;
  assign es_unlock_o     = es_unlock_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign status_o        = status_q;
  assign hit_pos_o       = hit_pos_q;
  assign hit_bounce_o    = hit_bounce_q;

endmodule
`default_nettype wire

// File: tb/tb_endstop_homing_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : tb_endstop_homing_ctrl
// Purpose   : Self-checking bench for endstop_homing_ctrl. Each run vector is
//             turned into an expected completion record by a timeline model;
//             the record is queued at start and popped when done pulses.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_endstop_homing_ctrl;

  localparam int SETTLE_W = 16;
  localparam int WDOG_W   = 32;
  localparam int POS_W    = 64;
  localparam int BIG      = 1000000;
  localparam int BOUND    = 300;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic                start_i, cancel_i, polarity_i, es_signal_i;
  logic [1:0]          axis_i;
  logic [SETTLE_W-1:0] settle_cycles_i;
  logic [WDOG_W-1:0]   watchdog_i;
  logic [POS_W-1:0]    es_pos_i;
  logic [31:0]         es_max_bounce_i;
  logic [1:0]          es_mux_select_o, status_o;
  logic                es_abort_pol_o, es_abort_en_o, es_unlock_o, busy_o, done_o;
  logic [POS_W-1:0]    hit_pos_o;
  logic [31:0]         hit_bounce_o;

  endstop_homing_ctrl #(.SETTLE_W(SETTLE_W), .WDOG_W(WDOG_W), .POS_W(POS_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .cancel_i(cancel_i),
    .axis_i(axis_i), .polarity_i(polarity_i), .settle_cycles_i(settle_cycles_i),
    .watchdog_i(watchdog_i), .es_signal_i(es_signal_i), .es_pos_i(es_pos_i),
    .es_max_bounce_i(es_max_bounce_i), .es_mux_select_o(es_mux_select_o),
    .es_abort_pol_o(es_abort_pol_o), .es_abort_en_o(es_abort_en_o),
    .es_unlock_o(es_unlock_o), .busy_o(busy_o), .done_o(done_o),
    .status_o(status_o), .hit_pos_o(hit_pos_o), .hit_bounce_o(hit_bounce_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] axis;
    logic       pol;
    int         settle;
    int         wdog;
    int         hd;        // hit delay after WAIT entry; -1 never, 0 already active
    int         cancel_at; // absolute cycle with cancel high; -1 none
    bit         restart;   // extra start pulse while busy
  } vec_t;

  typedef struct {
    int          done_cyc;
    logic [1:0]  status;
    logic [63:0] pos;
    logic [31:0] bounce;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          run_id = 0;
  logic [63:0] m_pos = '0;
  logic [31:0] m_bounce = '0;
  logic [1:0]  m_mux = '0;
  logic        m_pol = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pos_of(input int c);
    return {32'hC0DE_0000 | 32'(run_id), 32'(c)};
  endfunction

  function automatic logic [31:0] bounce_of(input int c);
    return 32'(run_id * 256 + c);
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   w, h, t, endc, act_from, abort_exp, abort_first_exp;
    int   unlock_cnt, unlock_first, abort_cnt, abort_first, done_cnt, busy_bad;
    run_id++;
    w        = 2 + v.settle;
    act_from = (v.hd == 0) ? 0 : w + v.hd;
    h        = (v.hd < 0) ? BIG : ((v.hd == 0) ? w : w + v.hd);
    t        = (v.wdog == 0) ? BIG : w + v.wdog - 1;
    endc     = (h < t) ? h : t;
    e.pos    = m_pos;
    e.bounce = m_bounce;
    if (v.axis == 2'd0) begin
      e.done_cyc = 1; e.status = 2'd2;
    end else begin
      m_mux = v.axis; m_pol = v.pol;
      if (v.cancel_at >= 1 && v.cancel_at <= endc) begin
        e.done_cyc = v.cancel_at + 1; e.status = 2'd3;
      end else if (h <= t) begin
        e.done_cyc = h + 1; e.status = 2'd0;
        e.pos = pos_of(h); e.bounce = bounce_of(h);
        m_pos = e.pos; m_bounce = e.bounce;
      end else begin
        e.done_cyc = t + 1; e.status = 2'd1;
      end
    end
    abort_exp       = (v.axis == 2'd0 || e.done_cyc <= w) ? 0 : e.done_cyc - w;
    abort_first_exp = (abort_exp > 0) ? w : -1;
    sb_q.push_back(e);

    // cycle 0: start pulse with run parameters
    start_i = 1'b1; cancel_i = 1'b0; axis_i = v.axis; polarity_i = v.pol;
    settle_cycles_i = SETTLE_W'(v.settle); watchdog_i = WDOG_W'(v.wdog);
    es_signal_i = (v.hd >= 0 && act_from == 0) ? v.pol : ~v.pol;
    es_pos_i = pos_of(0); es_max_bounce_i = bounce_of(0);
    unlock_cnt = 0; unlock_first = -1; abort_cnt = 0; abort_first = -1;
    done_cnt = 0; busy_bad = 0;

    for (int c = 1; c <= BOUND; c++) begin
      @(posedge clk); #1;
      if (es_unlock_o) begin unlock_cnt++; if (unlock_first < 0) unlock_first = c; end
      if (es_abort_en_o) begin abort_cnt++; if (abort_first < 0) abort_first = c; end
      if (busy_o !== (c <= e.done_cyc)) busy_bad++;
      if (done_o) begin
        done_cnt++;
        if (sb_q.size() > 0) begin
          exp_t got;
          got = sb_q.pop_front();
          chk("done_cycle", 64'(c), 64'(got.done_cyc));
          chk("status", 64'(status_o), 64'(got.status));
          chk("hit_pos", hit_pos_o, got.pos);
          chk("hit_bounce", 64'(hit_bounce_o), 64'(got.bounce));
        end
      end
      start_i  = (v.restart && c == 3);
      axis_i   = (v.restart && c == 3) ? 2'd3 : v.axis;
      cancel_i = (c == v.cancel_at);
      es_signal_i = (v.hd >= 0 && c >= act_from) ? v.pol : ~v.pol;
      es_pos_i = pos_of(c); es_max_bounce_i = bounce_of(c);
      if (c >= e.done_cyc + 2) break;
    end
    start_i = 1'b0; cancel_i = 1'b0;
    while (sb_q.size() > 0) void'(sb_q.pop_front());

    chk("done_count", 64'(done_cnt), 64'd1);
    chk("unlock_count", 64'(unlock_cnt), (v.axis == 2'd0) ? 64'd0 : 64'd1);
    chk("unlock_cycle", 64'(unlock_first), (v.axis == 2'd0) ? -64'sd1 : 64'd1);
    chk("abort_cycles", 64'(abort_cnt), 64'(abort_exp));
    chk("abort_first", 64'(abort_first), 64'(abort_first_exp));
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("mux_after", 64'(es_mux_select_o), 64'(m_mux));
    chk("pol_after", 64'(es_abort_pol_o), 64'(m_pol));
    chk("status_hold", 64'(status_o), 64'(e.status));
  endtask

  vec_t vecs[10];

  initial begin
    //          axis  pol   settle wdog hd  cancel restart
    vecs[0] = '{2'd2, 1'b1, 4,     0,   10, -1,    1'b1}; // hit after settle, restart ignored
    vecs[1] = '{2'd1, 1'b0, 0,     20,  -1, -1,    1'b0}; // watchdog timeout
    vecs[2] = '{2'd0, 1'b1, 3,     5,   -1, -1,    1'b0}; // bad axis
    vecs[3] = '{2'd3, 1'b1, 3,     0,   5,  10,    1'b0}; // cancel same cycle as hit
    vecs[4] = '{2'd1, 1'b1, 2,     50,  0,  -1,    1'b0}; // already active
    vecs[5] = '{2'd2, 1'b0, 1,     5,   4,  -1,    1'b0}; // hit and expiry together
    vecs[6] = '{2'd3, 1'b0, 6,     0,   -1, 4,     1'b0}; // cancel in SETTLE
    vecs[7] = '{2'd1, 1'b1, 3,     0,   -1, 1,     1'b0}; // cancel in ARM
    vecs[8] = '{2'd1, 1'b0, 0,     1,   -1, -1,    1'b0}; // one-cycle watchdog
    vecs[9] = '{2'd2, 1'b0, 1,     0,   2,  -1,    1'b0}; // short settle hit

    rst_ni = 1'b0; start_i = 1'b0; cancel_i = 1'b0; axis_i = '0; polarity_i = 1'b0;
    settle_cycles_i = '0; watchdog_i = '0; es_signal_i = 1'b0; es_pos_i = '0;
    es_max_bounce_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({es_mux_select_o, es_abort_pol_o, es_abort_en_o, es_unlock_o,
                           busy_o, done_o, status_o}), 64'd0);
    chk("reset_pos", hit_pos_o, 64'd0);
    chk("reset_bounce", 64'(hit_bounce_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // cancel while idle must not start anything
    begin
      int bad = 0;
      cancel_i = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        if (busy_o || done_o) bad++;
      end
      cancel_i = 1'b0;
      chk("idle_cancel", 64'(bad), 64'd0);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // reset asserted during WAIT: outputs clear without a clock edge, no done
    begin
      int bad = 0;
      run_id++;
      start_i = 1'b1; axis_i = 2'd2; polarity_i = 1'b1; settle_cycles_i = 16'd1;
      watchdog_i = '0; es_signal_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      chk("wait_abort_en", 64'(es_abort_en_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_reset_ctrl", 64'({es_mux_select_o, es_abort_pol_o, es_abort_en_o,
                                   es_unlock_o, busy_o, done_o, status_o}), 64'd0);
      chk("async_reset_pos", hit_pos_o, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (done_o || busy_o || es_abort_en_o) bad++;
      end
      chk("no_done_after_reset", 64'(bad), 64'd0);
      m_pos = '0; m_bounce = '0; m_mux = '0; m_pol = 1'b0;
    end

    run_vec('{2'd3, 1'b1, 2, 30, 3, -1, 1'b0}); // recovery run after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
